// File: rtl/countdown_timer.sv
// Loadable down-counter: accepts an interval over valid/ready and decrements it on enabled cycles.
// Emits a one-cycle done pulse at terminal count and can optionally reload for periodic operation.
module countdown_timer #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_value,
    input  logic             enable,
    input  logic             auto_reload,
    input  logic             abort,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] count_nx;
    logic [WIDTH-1:0] reload_reg, reload_nx;
    logic             done_nx;

    assign load_ready = (state == IDLE);
    assign busy       = (state == RUN);

    // State, count, reload value and done pulse registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            count      <= '0;
            reload_reg <= '0;
            done       <= 1'b0;
        end else begin
            state      <= state_nx;
            count      <= count_nx;
            reload_reg <= reload_nx;
            done       <= done_nx;
        end
    end

    // Next-state and datapath decisions
    always_comb begin
        state_nx  = state;
        count_nx  = count;
        reload_nx = reload_reg;
        done_nx   = 1'b0;
        case (state)
            IDLE: begin
                if (load_valid) begin
                    reload_nx = load_value;
                    if (load_value != '0) begin
                        count_nx = load_value;
                        state_nx = RUN;
                    end else begin
                        done_nx = 1'b1;
                    end
                end
            end
            RUN: begin
                if (abort) begin
                    count_nx = '0;
                    state_nx = IDLE;
                end else if (enable) begin
                    if (count > WIDTH'(1)) begin
                        count_nx = count - WIDTH'(1);
                    end else begin
                        // Terminal tick; count of 0 cannot occur in RUN, treated as terminal too
                        done_nx = 1'b1;
                        if (auto_reload) begin
                            count_nx = reload_reg;
                        end else begin
                            count_nx = '0;
                            state_nx = IDLE;
                        end
                    end
                end
            end
            default: begin
                count_nx = '0;
                state_nx = IDLE;
            end
        endcase
    end

endmodule
